// File: rtl/rename_int.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rename_int                                                    |
// | Purpose  : Integer register-rename stage. Allocates destination physical |
// |            registers from the freelist, translates sources/destinations  |
// |            through the speculative map (with intra-group bypass) and     |
// |            registers the renamed group for dispatch. A committed map,    |
// |            written at ROB commit, restores the speculative map on        |
// |            recover.                                                      |
// | Ports    : clock/reset       - clock, synchronous active-high reset      |
// |            recover           - flush output, restore spec map            |
// |            in_* / uop, rs*, rd, rd_valid - decoded group input          |
// |            prf_req/prf_in/allocatable    - freelist handshake           |
// |            out_* / prs*, prd, old_prd    - renamed group output         |
// |            commit_*          - committed-map write ports                 |
// |            wb_*, prs*_ready  - busy table (RENAME_BUSY_TABLE_EN only)    |
// | Options  : `define RENAME_BUSY_TABLE_EN adds the busy table and the       |
// |            wb_* / prs*_ready ports.                                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module rename_int #(
   parameter int RENAME_WIDTH   = 4,
   parameter int ARF_SIZE       = 32,
   parameter int PRF_SIZE       = 64,
   parameter int PRF_INDEX_SIZE = 6,
   parameter int WB_WIDTH       = 4
) (
   input  logic                                   clock,
   input  logic                                   reset,
   input  logic                                   recover,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic [RENAME_WIDTH-1:0]                uop_valid,
   input  logic [RENAME_WIDTH*5-1:0]              rs1,
   input  logic [RENAME_WIDTH*5-1:0]              rs2,
   input  logic [RENAME_WIDTH*5-1:0]              rd,
   input  logic [RENAME_WIDTH-1:0]                rd_valid,
   output logic [RENAME_WIDTH-1:0]                prf_req,
   input  logic [RENAME_WIDTH*PRF_INDEX_SIZE-1:0] prf_in,
   input  logic                                   allocatable,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [RENAME_WIDTH-1:0]                out_uop_valid,
   output logic [RENAME_WIDTH*PRF_INDEX_SIZE-1:0] prs1,
   output logic [RENAME_WIDTH*PRF_INDEX_SIZE-1:0] prs2,
   output logic [RENAME_WIDTH*PRF_INDEX_SIZE-1:0] prd,
   output logic [RENAME_WIDTH*PRF_INDEX_SIZE-1:0] old_prd,
`ifdef RENAME_BUSY_TABLE_EN
   input  logic [WB_WIDTH-1:0]                    wb_valid,
   input  logic [WB_WIDTH*PRF_INDEX_SIZE-1:0]     wb_prd,
   output logic [RENAME_WIDTH-1:0]                prs1_ready,
   output logic [RENAME_WIDTH-1:0]                prs2_ready,
`endif
   input  logic [RENAME_WIDTH-1:0]                commit_valid,
   input  logic [RENAME_WIDTH*5-1:0]              commit_rd,
   input  logic [RENAME_WIDTH*PRF_INDEX_SIZE-1:0] commit_prd
);

   localparam int AR_IDX_W = 5;
   localparam int P        = PRF_INDEX_SIZE;

   // Elaboration-time sanity check of the configuration.
   if ((PRF_SIZE != (1 << PRF_INDEX_SIZE)) || (WB_WIDTH < 1) || (ARF_SIZE > 32)) begin : g_cfg_check
      $error("rename_int: inconsistent PRF_SIZE/PRF_INDEX_SIZE/WB_WIDTH/ARF_SIZE");
   end

   // ---------------------------------------------------------------------
   // Map tables
   // ---------------------------------------------------------------------
   logic [P-1:0] spec_rat_q [ARF_SIZE];
   logic [P-1:0] spec_rat_d [ARF_SIZE];
   logic [P-1:0] arch_rat_q [ARF_SIZE];
   logic [P-1:0] arch_rat_d [ARF_SIZE];

   // ---------------------------------------------------------------------
   // Handshake
   // ---------------------------------------------------------------------
   logic [RENAME_WIDTH-1:0] need;
   logic                    stage_free;
   logic                    fire;
   logic                    out_valid_q;

   always_comb begin
      for (int i = 0; i < RENAME_WIDTH; i++) begin
         need[i] = uop_valid[i] & rd_valid[i] & (rd[i*AR_IDX_W +: AR_IDX_W] != '0);
      end
   end

   assign stage_free = ~out_valid_q | out_ready;
   // prf_req deliberately ignores allocatable: the freelist decides itself
   // whether to commit the allocation, so requesting only in firable cycles
   // is enough to keep both sides in step.
   assign prf_req    = {RENAME_WIDTH{in_valid & stage_free & ~recover}} & need;
   assign in_ready   = stage_free & allocatable & ~recover;
   assign fire       = in_valid & in_ready;

   // ---------------------------------------------------------------------
   // Source / old-destination lookup with intra-group bypass. Scanning
   // older slots in ascending order leaves the youngest match in place.
   // ---------------------------------------------------------------------
   logic [RENAME_WIDTH*P-1:0] prs1_d, prs2_d, prd_d, old_prd_d;
   logic [RENAME_WIDTH-1:0]   src1_fwd, src2_fwd;

   always_comb begin
      for (int i = 0; i < RENAME_WIDTH; i++) begin
         prs1_d[i*P +: P]    = spec_rat_q[rs1[i*AR_IDX_W +: AR_IDX_W]];
         prs2_d[i*P +: P]    = spec_rat_q[rs2[i*AR_IDX_W +: AR_IDX_W]];
         old_prd_d[i*P +: P] = spec_rat_q[rd[i*AR_IDX_W +: AR_IDX_W]];
         src1_fwd[i]         = 1'b0;
         src2_fwd[i]         = 1'b0;
         for (int j = 0; j < i; j++) begin
            if (need[j] && (rd[j*AR_IDX_W +: AR_IDX_W] == rs1[i*AR_IDX_W +: AR_IDX_W])) begin
               prs1_d[i*P +: P] = prf_in[j*P +: P];
               src1_fwd[i]      = 1'b1;
            end
            if (need[j] && (rd[j*AR_IDX_W +: AR_IDX_W] == rs2[i*AR_IDX_W +: AR_IDX_W])) begin
               prs2_d[i*P +: P] = prf_in[j*P +: P];
               src2_fwd[i]      = 1'b1;
            end
            if (need[j] && (rd[j*AR_IDX_W +: AR_IDX_W] == rd[i*AR_IDX_W +: AR_IDX_W])) begin
               old_prd_d[i*P +: P] = prf_in[j*P +: P];
            end
         end
         // x0 is hard-wired to p0 regardless of map contents.
         if (rs1[i*AR_IDX_W +: AR_IDX_W] == '0) begin
            prs1_d[i*P +: P] = '0;
            src1_fwd[i]      = 1'b0;
         end
         if (rs2[i*AR_IDX_W +: AR_IDX_W] == '0) begin
            prs2_d[i*P +: P] = '0;
            src2_fwd[i]      = 1'b0;
         end
         if (rd[i*AR_IDX_W +: AR_IDX_W] == '0) begin
            old_prd_d[i*P +: P] = '0;
         end
         prd_d[i*P +: P] = need[i] ? prf_in[i*P +: P] : '0;
      end
   end

   // ---------------------------------------------------------------------
   // Map table next state. Ascending slot order makes the highest slot win
   // on duplicate destinations. Recover copies the committed map including
   // this cycle's commits.
   // ---------------------------------------------------------------------
   always_comb begin
      arch_rat_d = arch_rat_q;
      for (int i = 0; i < RENAME_WIDTH; i++) begin
         if (commit_valid[i] && (commit_rd[i*AR_IDX_W +: AR_IDX_W] != '0)) begin
            arch_rat_d[commit_rd[i*AR_IDX_W +: AR_IDX_W]] = commit_prd[i*P +: P];
         end
      end
      spec_rat_d = spec_rat_q;
      if (recover) begin
         spec_rat_d = arch_rat_d;
      end else if (fire) begin
         for (int i = 0; i < RENAME_WIDTH; i++) begin
            if (need[i]) begin
               spec_rat_d[rd[i*AR_IDX_W +: AR_IDX_W]] = prf_in[i*P +: P];
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int a = 0; a < ARF_SIZE; a++) begin
            spec_rat_q[a] <= '0;
            arch_rat_q[a] <= '0;
         end
      end else begin
         spec_rat_q <= spec_rat_d;
         arch_rat_q <= arch_rat_d;
      end
   end

   // ---------------------------------------------------------------------
   // Output register
   // ---------------------------------------------------------------------
   logic [RENAME_WIDTH-1:0]   out_uop_valid_q;
   logic [RENAME_WIDTH*P-1:0] prs1_q, prs2_q, prd_q, old_prd_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid_q     <= 1'b0;
         out_uop_valid_q <= '0;
         prs1_q          <= '0;
         prs2_q          <= '0;
         prd_q           <= '0;
         old_prd_q       <= '0;
      end else if (recover) begin
         out_valid_q     <= 1'b0;
      end else if (fire) begin
         out_valid_q     <= 1'b1;
         out_uop_valid_q <= uop_valid;
         prs1_q          <= prs1_d;
         prs2_q          <= prs2_d;
         prd_q           <= prd_d;
         old_prd_q       <= old_prd_d;
      end else if (out_ready) begin
         out_valid_q     <= 1'b0;
      end
   end

   assign out_valid     = out_valid_q;
   assign out_uop_valid = out_uop_valid_q;
   assign prs1          = prs1_q;
   assign prs2          = prs2_q;
   assign prd           = prd_q;
   assign old_prd       = old_prd_q;

`ifdef RENAME_BUSY_TABLE_EN
   // ---------------------------------------------------------------------
   // Busy table: set on allocation, cleared on writeback, set wins.
   // ---------------------------------------------------------------------
   logic [PRF_SIZE-1:0]     busy_q, busy_d;
   logic [RENAME_WIDTH-1:0] prs1_ready_d, prs2_ready_d;
   logic [RENAME_WIDTH-1:0] prs1_ready_q, prs2_ready_q;

   always_comb begin
      busy_d = busy_q;
      for (int k = 0; k < WB_WIDTH; k++) begin
         if (wb_valid[k]) begin
            busy_d[wb_prd[k*P +: P]] = 1'b0;
         end
      end
      if (fire) begin
         for (int i = 0; i < RENAME_WIDTH; i++) begin
            if (need[i]) begin
               busy_d[prf_in[i*P +: P]] = 1'b1;
            end
         end
      end
      busy_d[0] = 1'b0;
   end

   // Ready = not busy, or being written back this cycle; a source produced
   // inside the same group can never be ready yet.
   always_comb begin
      for (int i = 0; i < RENAME_WIDTH; i++) begin
         prs1_ready_d[i] = ~busy_q[prs1_d[i*P +: P]];
         prs2_ready_d[i] = ~busy_q[prs2_d[i*P +: P]];
         for (int k = 0; k < WB_WIDTH; k++) begin
            if (wb_valid[k] && (wb_prd[k*P +: P] == prs1_d[i*P +: P])) prs1_ready_d[i] = 1'b1;
            if (wb_valid[k] && (wb_prd[k*P +: P] == prs2_d[i*P +: P])) prs2_ready_d[i] = 1'b1;
         end
         if (src1_fwd[i]) prs1_ready_d[i] = 1'b0;
         if (src2_fwd[i]) prs2_ready_d[i] = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         busy_q       <= '0;
         prs1_ready_q <= '0;
         prs2_ready_q <= '0;
      end else if (recover) begin
         busy_q       <= '0;
      end else begin
         busy_q <= busy_d;
         if (fire) begin
            prs1_ready_q <= prs1_ready_d;
            prs2_ready_q <= prs2_ready_d;
         end
      end
   end

   assign prs1_ready = prs1_ready_q;
   assign prs2_ready = prs2_ready_q;
`else
   // Fast-forward flags only feed the busy table.
   logic w_unused_fwd;
   assign w_unused_fwd = ^{src1_fwd, src2_fwd};
`endif

endmodule
`default_nettype wire

// File: tb/tb_rename_int.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_rename_int                                                 |
// | Purpose  : Self-checking bench for rename_int (table vectors plus        |
// |            hand-written stall / backpressure / recover sequences).       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_rename_int;

   localparam int RW = 4;
   localparam int P  = 6;

   logic clock = 1'b0;
   logic reset, recover, in_valid, in_ready, allocatable, out_valid, out_ready;
   logic [RW-1:0]   uop_valid, rd_valid, prf_req, out_uop_valid, commit_valid;
   logic [RW*5-1:0] rs1, rs2, rd, commit_rd;
   logic [RW*P-1:0] prf_in, prs1, prs2, prd, old_prd, commit_prd;
`ifdef RENAME_BUSY_TABLE_EN
   logic [3:0]      wb_valid;
   logic [4*P-1:0]  wb_prd;
   logic [RW-1:0]   prs1_ready, prs2_ready;
`endif

   always #5 clock = ~clock;

   rename_int dut (
      .clock(clock), .reset(reset), .recover(recover),
      .in_valid(in_valid), .in_ready(in_ready),
      .uop_valid(uop_valid), .rs1(rs1), .rs2(rs2), .rd(rd), .rd_valid(rd_valid),
      .prf_req(prf_req), .prf_in(prf_in), .allocatable(allocatable),
      .out_valid(out_valid), .out_ready(out_ready), .out_uop_valid(out_uop_valid),
      .prs1(prs1), .prs2(prs2), .prd(prd), .old_prd(old_prd),
`ifdef RENAME_BUSY_TABLE_EN
      .wb_valid(wb_valid), .wb_prd(wb_prd),
      .prs1_ready(prs1_ready), .prs2_ready(prs2_ready),
`endif
      .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_prd(commit_prd)
   );

   typedef struct packed {
      logic [3:0]  uv;
      logic [23:0] prs1, prs2, prd, old;
      logic [3:0]  r1, r2;
   } out_t;

   typedef struct packed {
      logic [3:0]  uv, rdv;
      logic [19:0] rs1, rs2, rd;
      logic [23:0] pin;
      logic [3:0]  req;
      out_t        exp;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   bit   chk_rdy = 1'b0;
   out_t sb[$];
   out_t cur;
   vec_t vecs [5];
   vec_t v;

   function automatic logic [19:0] p5(input int a0, input int a1, input int a2, input int a3);
      return {a3[4:0], a2[4:0], a1[4:0], a0[4:0]};
   endfunction

   function automatic logic [23:0] p6(input int a0, input int a1, input int a2, input int a3);
      return {a3[5:0], a2[5:0], a1[5:0], a0[5:0]};
   endfunction

   function automatic out_t mk_out(input logic [3:0] uv, input logic [23:0] a, input logic [23:0] b,
                                   input logic [23:0] d, input logic [23:0] o,
                                   input logic [3:0] r1, input logic [3:0] r2);
      out_t t;
      t.uv = uv; t.prs1 = a; t.prs2 = b; t.prd = d; t.old = o; t.r1 = r1; t.r2 = r2;
      return t;
   endfunction

   function automatic vec_t mk_vec(input logic [3:0] uv, input logic [3:0] rdv, input logic [19:0] a,
                                   input logic [19:0] b, input logic [19:0] d, input logic [23:0] pin,
                                   input logic [3:0] req, input out_t e);
      vec_t t;
      t.uv = uv; t.rdv = rdv; t.rs1 = a; t.rs2 = b; t.rd = d; t.pin = pin; t.req = req; t.exp = e;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic apply(input vec_t t);
      in_valid  = 1'b1;
      uop_valid = t.uv;
      rd_valid  = t.rdv;
      rs1       = t.rs1;
      rs2       = t.rs2;
      rd        = t.rd;
      prf_in    = t.pin;
   endtask

   // Advance one clock; on an expected fire, pop the next expected group
   // from the scoreboard, then compare the output register.
   task automatic tick(input bit exp_fire, input bit exp_ov);
      @(posedge clock);
      #1;
      if (exp_fire) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got empty queue expected a pending group");
         end else begin
            cur = sb.pop_front();
         end
      end
      chk("out_valid", out_valid, exp_ov);
      if (exp_ov) begin
         chk("out_uop_valid", out_uop_valid, cur.uv);
         chk("prs1", prs1, cur.prs1);
         chk("prs2", prs2, cur.prs2);
         chk("prd", prd, cur.prd);
         chk("old_prd", old_prd, cur.old);
`ifdef RENAME_BUSY_TABLE_EN
         if (chk_rdy) begin
            chk("prs1_ready", prs1_ready, cur.r1);
            chk("prs2_ready", prs2_ready, cur.r2);
         end
`endif
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; recover = 1'b0; in_valid = 1'b0; allocatable = 1'b1; out_ready = 1'b1;
      uop_valid = '0; rd_valid = '0; rs1 = '0; rs2 = '0; rd = '0; prf_in = '0;
      commit_valid = '0; commit_rd = '0; commit_prd = '0;
`ifdef RENAME_BUSY_TABLE_EN
      wb_valid = '0; wb_prd = '0;
`endif

      // Hand-computed groups from the reset map (all registers -> p0).
      vecs[0] = mk_vec(4'b0001, 4'b0001, p5(2,0,0,0), p5(3,0,0,0), p5(1,0,0,0), p6(5,0,0,0), 4'b0001,
                       mk_out(4'b0001, p6(0,0,0,0), p6(0,0,0,0), p6(5,0,0,0), p6(0,0,0,0), 4'hf, 4'hf));
      vecs[1] = mk_vec(4'b0111, 4'b0111, p5(0,4,4,0), p5(0,0,1,0), p5(4,5,4,0), p6(7,8,9,0), 4'b0111,
                       mk_out(4'b0111, p6(0,7,7,0), p6(0,0,5,0), p6(7,8,9,0), p6(0,0,7,0), 4'hf, 4'hf));
      vecs[2] = mk_vec(4'b1111, 4'b1101, p5(4,6,4,1), p5(5,1,7,6), p5(6,7,0,1), p6(10,33,34,11), 4'b1001,
                       mk_out(4'b1111, p6(9,10,9,5), p6(8,5,0,10), p6(10,0,0,11), p6(0,0,0,5), 4'hf, 4'hf));
      vecs[3] = mk_vec(4'b1111, 4'b1111, p5(0,2,2,1), p5(0,0,0,0), p5(2,2,3,2), p6(12,13,14,15), 4'b1111,
                       mk_out(4'b1111, p6(0,12,13,11), p6(0,0,0,0), p6(12,13,14,15), p6(0,12,0,13), 4'hf, 4'hf));
      vecs[4] = mk_vec(4'b0010, 4'b0011, p5(3,9,0,0), p5(2,2,0,0), p5(9,9,0,0), p6(20,21,0,0), 4'b0010,
                       mk_out(4'b0010, p6(14,0,0,0), p6(15,15,0,0), p6(0,21,0,0), p6(0,0,0,0), 4'hf, 4'hf));

      // Reset state
      repeat (3) @(posedge clock);
      #1;
      chk("rst out_valid", out_valid, 1'b0);
      chk("rst out_uop_valid", out_uop_valid, 4'b0);
      chk("rst prd", prd, 24'h0);
      chk("rst prs1", prs1, 24'h0);
      chk("rst old_prd", old_prd, 24'h0);
      chk("rst in_ready", in_ready, 1'b1);
      chk("rst prf_req", prf_req, 4'b0);
      reset = 1'b0;

      // Table-driven groups, back to back, downstream always ready
      for (int i = 0; i < 5; i++) begin
         apply(vecs[i]);
         sb.push_back(vecs[i].exp);
         #1;
         chk("tbl in_ready", in_ready, 1'b1);
         chk("tbl prf_req", prf_req, vecs[i].req);
         tick(1'b1, 1'b1);
      end

      // Freelist stall for 3 cycles, then exactly one fire
      v = mk_vec(4'b0001, 4'b0001, p5(9,0,0,0), p5(0,0,0,0), p5(10,0,0,0), p6(22,0,0,0), 4'b0001,
                 mk_out(4'b0001, p6(21,0,0,0), 24'h0, p6(22,0,0,0), 24'h0, 4'hf, 4'hf));
      apply(v);
      sb.push_back(v.exp);
      allocatable = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("stall in_ready", in_ready, 1'b0);
         chk("stall prf_req", prf_req, 4'b0001);
         tick(1'b0, 1'b0);
      end
      allocatable = 1'b1;
      #1;
      chk("unstall in_ready", in_ready, 1'b1);
      chk("unstall prf_req", prf_req, 4'b0001);
      tick(1'b1, 1'b1);
      in_valid = 1'b0;
      #1;
      chk("idle prf_req", prf_req, 4'b0);
      tick(1'b0, 1'b0);

      // Downstream backpressure: output held, no request, then replacement
      out_ready = 1'b0;
      v = mk_vec(4'b0001, 4'b0001, p5(10,0,0,0), p5(0,0,0,0), p5(11,0,0,0), p6(23,0,0,0), 4'b0001,
                 mk_out(4'b0001, p6(22,0,0,0), 24'h0, p6(23,0,0,0), 24'h0, 4'hf, 4'hf));
      apply(v);
      sb.push_back(v.exp);
      #1;
      chk("bp first in_ready", in_ready, 1'b1);
      tick(1'b1, 1'b1);
      v = mk_vec(4'b0001, 4'b0001, p5(11,0,0,0), p5(0,0,0,0), p5(12,0,0,0), p6(24,0,0,0), 4'b0001,
                 mk_out(4'b0001, p6(23,0,0,0), 24'h0, p6(24,0,0,0), 24'h0, 4'hf, 4'hf));
      apply(v);
      sb.push_back(v.exp);
      for (int c = 0; c < 2; c++) begin
         #1;
         chk("bp in_ready", in_ready, 1'b0);
         chk("bp prf_req", prf_req, 4'b0);
         tick(1'b0, 1'b1);
      end
      out_ready = 1'b1;
      #1;
      chk("bp release in_ready", in_ready, 1'b1);
      chk("bp release prf_req", prf_req, 4'b0001);
      tick(1'b1, 1'b1);
      in_valid = 1'b0;
      tick(1'b0, 1'b0);

      // Rename x1->p5, commit x1 (highest commit port p3 wins), recover
      v = mk_vec(4'b0001, 4'b0001, p5(0,0,0,0), p5(0,0,0,0), p5(1,0,0,0), p6(5,0,0,0), 4'b0001,
                 mk_out(4'b0001, 24'h0, 24'h0, p6(5,0,0,0), p6(11,0,0,0), 4'hf, 4'hf));
      apply(v);
      sb.push_back(v.exp);
      #1;
      chk("rec pre in_ready", in_ready, 1'b1);
      tick(1'b1, 1'b1);
      out_ready    = 1'b0;
      recover      = 1'b1;
      commit_valid = 4'b0111;
      commit_rd    = p5(1,0,1,0);
      commit_prd   = p6(40,50,3,0);
      v = mk_vec(4'b0001, 4'b0001, p5(1,0,0,0), p5(4,0,0,0), p5(2,0,0,0), p6(30,0,0,0), 4'b0001,
                 mk_out(4'b0001, p6(3,0,0,0), 24'h0, p6(30,0,0,0), 24'h0, 4'hf, 4'hf));
      apply(v);
      #1;
      chk("rec in_ready", in_ready, 1'b0);
      chk("rec prf_req", prf_req, 4'b0);
      tick(1'b0, 1'b0);
      recover = 1'b0; commit_valid = '0; out_ready = 1'b1;
      sb.push_back(v.exp);
      #1;
      chk("post rec in_ready", in_ready, 1'b1);
      tick(1'b1, 1'b1);
      in_valid = 1'b0;
      tick(1'b0, 1'b0);

`ifdef RENAME_BUSY_TABLE_EN
      // Busy table: producer, dependent consumers, writeback bypass
      chk_rdy = 1'b1;
      v = mk_vec(4'b0001, 4'b0001, p5(0,0,0,0), p5(0,0,0,0), p5(1,0,0,0), p6(5,0,0,0), 4'b0001,
                 mk_out(4'b0001, 24'h0, 24'h0, p6(5,0,0,0), p6(3,0,0,0), 4'hf, 4'hf));
      apply(v); sb.push_back(v.exp); tick(1'b1, 1'b1);
      v = mk_vec(4'b0011, 4'b0011, p5(1,2,0,0), p5(0,0,0,0), p5(2,3,0,0), p6(6,7,0,0), 4'b0011,
                 mk_out(4'b0011, p6(5,6,0,0), 24'h0, p6(6,7,0,0), p6(30,0,0,0), 4'b1100, 4'hf));
      apply(v); sb.push_back(v.exp); tick(1'b1, 1'b1);
      wb_valid = 4'b0001; wb_prd = p6(5,0,0,0);
      v = mk_vec(4'b0001, 4'b0001, p5(1,0,0,0), p5(0,0,0,0), p5(4,0,0,0), p6(8,0,0,0), 4'b0001,
                 mk_out(4'b0001, p6(5,0,0,0), 24'h0, p6(8,0,0,0), 24'h0, 4'hf, 4'hf));
      apply(v); sb.push_back(v.exp); tick(1'b1, 1'b1);
      wb_valid = '0;
      v = mk_vec(4'b0001, 4'b0001, p5(1,0,0,0), p5(2,0,0,0), p5(5,0,0,0), p6(9,0,0,0), 4'b0001,
                 mk_out(4'b0001, p6(5,0,0,0), p6(6,0,0,0), p6(9,0,0,0), 24'h0, 4'hf, 4'b1110));
      apply(v); sb.push_back(v.exp); tick(1'b1, 1'b1);
      in_valid = 1'b0;
      tick(1'b0, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
